// File: rtl/stream_frame_writer.sv
// Avalon-ST raster sink: checks packet framing, packs 10:10:10 RGB into 4:4:4
// and writes pixels linearly into the frame buffer, one pixel per clock.
module stream_frame_writer #(
  parameter int WIDTH  = 320,
  parameter int HEIGHT = 240,
  parameter int ADDR_W = 17
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [29:0]       snk_data_i,
  input  logic              snk_valid_i,
  output logic              snk_ready_o,
  input  logic              snk_sop_i,
  input  logic              snk_eop_i,
  input  logic              freeze_i,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [11:0]       wr_data_o,
  output logic              wr_en_o,
  output logic              frame_done_o,
  output logic              frame_err_o,
  output logic [7:0]        frame_count_o
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RECV = 2'd1;
  localparam logic [1:0] DROP = 2'd2;

  localparam int unsigned PIXELS = WIDTH * HEIGHT;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(PIXELS - 1);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] p_q, p_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [11:0]       data_q, data_d;
  logic              wr_en_q, wr_en_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [7:0]        count_q, count_d;

  logic              accept;
  logic              startFrame;
  logic              writeBeat;
  logic [ADDR_W-1:0] idx;
  logic [11:0]       pixel444;
  logic              unused_data;

  assign snk_ready_o = !reset_i;
  assign accept      = snk_valid_i && snk_ready_o;
  assign pixel444    = {snk_data_i[29:26], snk_data_i[19:16], snk_data_i[9:6]};
  assign unused_data = ^{snk_data_i[25:20], snk_data_i[15:10], snk_data_i[5:0]};

  // A sop in any state funnels through startFrame; every written beat then
  // shares one framing decision based on its pixel index and eop.
  always_comb begin
    state_d    = state_q;
    p_d        = p_q;
    addr_d     = addr_q;
    data_d     = data_q;
    wr_en_d    = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;
    count_d    = count_q;
    startFrame = 1'b0;
    writeBeat  = 1'b0;
    idx        = '0;

    if (accept) begin
      case (state_q)
        RECV: begin
          if (snk_sop_i) begin
            err_d      = 1'b1;
            startFrame = 1'b1;
          end else begin
            writeBeat = 1'b1;
            idx       = p_q;
          end
        end
        DROP: begin
          if (snk_sop_i) startFrame = 1'b1;
          else if (snk_eop_i) state_d = IDLE;
        end
        default: begin
          if (snk_sop_i) startFrame = 1'b1;
        end
      endcase
    end

    if (startFrame) begin
      if (freeze_i) begin
        state_d = snk_eop_i ? IDLE : DROP;
      end else begin
        writeBeat = 1'b1;
        idx       = '0;
      end
    end

    if (writeBeat) begin
      wr_en_d = 1'b1;
      addr_d  = idx;
      data_d  = pixel444;
      if (idx == LAST) begin
        if (snk_eop_i) begin
          done_d  = 1'b1;
          count_d = count_q + 8'd1;
          state_d = IDLE;
        end else begin
          err_d   = 1'b1;
          state_d = DROP;
        end
      end else if (snk_eop_i) begin
        err_d   = 1'b1;
        state_d = IDLE;
      end else begin
        p_d     = idx + ADDR_W'(1);
        state_d = RECV;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      p_q     <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      wr_en_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      wr_en_q <= wr_en_d;
      done_q  <= done_d;
      err_q   <= err_d;
      count_q <= count_d;
    end
  end

  assign wr_addr_o     = addr_q;
  assign wr_data_o     = data_q;
  assign wr_en_o       = wr_en_q;
  assign frame_done_o  = done_q;
  assign frame_err_o   = err_q;
  assign frame_count_o = count_q;

endmodule

// File: doc/stream_frame_writer.md
# stream_frame_writer

Avalon-ST video sink that receives a raster pixel stream (startofpacket/endofpacket/valid/ready, 30-bit RGB) and writes it into the 12-bit dual-clock frame buffer as a linear raster. It is the write-side counterpart of the row/column frame reader that streams the frame buffer into the video scaler. Processed frames, such as the edge-filtered or grayscale output, can be captured back into memory through this block. It validates packet framing, converts 10:10:10 RGB to 4:4:4, and reports completed and malformed frames.

## Interface
- WIDTH, 320, pixels per line
- HEIGHT, 240, lines per frame
- ADDR_W, 17, frame buffer address width; must satisfy 2^ADDR_W >= WIDTH*HEIGHT
- clk  in  1  pixel clock (clk_25_vga domain)
- reset  in  1  synchronous, active-high
- snk_data  in  30  {R[29:20], G[19:10], B[9:0]}
- snk_valid  in  1  beat valid
- snk_ready  out  1  sink ready
- snk_sop  in  1  startofpacket
- snk_eop  in  1  endofpacket
- freeze  in  1  when high, frames that start are discarded rather than written
- wr_addr  out  ADDR_W  frame buffer write address
- wr_data  out  12  {R[9:6], G[9:6], B[9:6]}
- wr_en  out  1  frame buffer write strobe
- frame_done  out  1  one-cycle pulse: a complete, well-formed frame has been written
- frame_err  out  1  one-cycle pulse: a framing error was detected
- frame_count  out  8  count of completed frames, wraps 255->0

## Operation
- A beat is accepted when snk_valid && snk_ready. snk_ready is 0 during reset and 1 otherwise; the block never back-pressures.
- Pixel index p runs from 0 to WIDTH*HEIGHT-1. LAST = WIDTH*HEIGHT-1. Addresses come from an incrementing counter, not a multiplier.
- States:
  - IDLE: waits for an accepted sop beat. Non-sop beats are discarded silently with no error. On sop with freeze=0: write pixel 0 and go to RECV (p=1). On sop with freeze=1: go to DROP, no write.
  - RECV: each accepted beat writes at address p, then p increments.
    - Beat at p==LAST with eop: write it, pulse frame_done, increment frame_count, go to IDLE.
    - Beat at p<LAST with eop: write it, pulse frame_err, go to IDLE.
    - Beat at p==LAST without eop: write it, pulse frame_err, go to DROP.
    - sop beat in RECV (restart): pulse frame_err and treat it as a new pixel 0. Write address 0, set p=1, stay in RECV. If freeze=1, go to DROP with no write.
  - DROP: discards beats with no writes. An accepted eop goes to IDLE. An accepted sop re-enters frame start using the IDLE rules; if that beat also carries eop, the eop rule applies.
- A beat with both sop and eop in IDLE is valid only when LAST==0. Otherwise: write pixel 0, pulse frame_err, go to IDLE.
- freeze is sampled only on sop beats; changing it mid-frame does not affect the frame in progress.
- Colour conversion keeps the top 4 bits of each 10-bit channel. There is no rounding.

## Timing
- Registered outputs. A beat accepted in cycle n gives wr_en/wr_addr/wr_data valid in cycle n+1.
- frame_done, frame_err, and the frame_count update appear in cycle n+1, aligned with the wr_en of the causing beat.
- wr_en is high for exactly one cycle per written beat. wr_addr and wr_data hold their last value when wr_en=0.
- Reset values:
  - state = IDLE, p = 0, snk_ready = 0
  - wr_en = 0, wr_addr = 0, wr_data = 0
  - frame_done = 0, frame_err = 0, frame_count = 0
- Reset asserted mid-frame: the next cycle is in IDLE with no wr_en and no pulses, and the partial frame is abandoned.
- Throughput: one pixel per clock, sustained. Back-to-back frames (eop in cycle n, sop in cycle n+1) have no lost beat.

## Test plan
(Bench uses WIDTH=4, HEIGHT=2, so LAST=7.)
- Well-formed frame: 8 beats, sop on beat 0, eop on beat 7, data {R=10'h3FF, G=10'h200, B=10'h0C0}.
  - Required: wr_en on 8 consecutive cycles, addr 0..7, wr_data=12'hF83.
  - Required: frame_done once, aligned with addr 7; frame_count=1; frame_err never.
- Early eop: sop then eop on beat 4.
  - Required: 5 writes (addr 0..4), frame_err pulse with addr 4, frame_done never.
  - Then a following good frame still writes addr 0..7 and gives frame_done.
- Missing eop: 10 beats, sop only.
  - Required: writes addr 0..7, frame_err with addr 7, beats 8-9 not written.
  - Then an eop beat, then a good frame, gives frame_done and frame_count=1.
- Restart: sop, 3 beats, sop again, 7 more beats with eop on the last.
  - Required: frame_err at the second sop's write, which is at addr 0.
  - Required: the rewrite covers addr 0..7 and ends in frame_done.
- freeze=1 at sop of a good frame: no wr_en, no pulses. freeze dropped mid-frame has no effect on it. The next frame with freeze=0 is written normally.
- Reset asserted at beat 3 of a frame: no further wr_en. The next clean frame writes addr 0..7, frame_count=1.
- Valid gaps: snk_valid toggles 1,0,1,0 through a good frame.
  - Required: 8 writes only on accepted cycles, addresses sequential, frame_done aligned with addr 7.
